// File: rtl/hiv1_assay_sequencer.sv
// HIV-1 p24 immunoassay chip sequencer: walks the 10-step valve/pump/mixer protocol
// with break-before-make settle phases, hold (pause) and abort handling.
module hiv1_assay_sequencer #(
    parameter int TW       = 16,
    parameter int TICK_DIV = 1,
    parameter int SETTLE   = 2,
    parameter int T_PRIME  = 4,
    parameter int T_FLOW   = 3,
    parameter int T_INC    = 5,
    parameter int T_WASH   = 4,
    parameter int T_READ   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       hold,
    input  logic       abort,
    output logic [1:0] sw41_sel,
    output logic [1:0] sw42_sel,
    output logic [1:0] sw31_sel,
    output logic       pump_en,
    output logic       mixer_en,
    output logic       read_strobe,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [3:0] step
);

    typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_ACTIVE, S_DONE, S_ABORT} state_t;

    typedef struct packed {
        logic [1:0] sw42;
        logic [1:0] sw41;
        logic [1:0] sw31;
        logic       pump;
        logic       mixer;
    } route_t;

    localparam int            PW            = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_RELOAD    = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0] SETTLE_RELOAD = TW'(SETTLE - 1);
    localparam logic [3:0]    LAST_STEP     = 4'd10;
    localparam logic [3:0]    STEP_ABORT    = 4'd15;

    // Reload value (ticks - 1) of the ACTIVE phase of each step.
    function automatic logic [TW-1:0] active_len(input logic [3:0] s);
        case (s)
            4'd1:       return TW'(T_PRIME - 1);
            4'd3, 4'd6: return TW'(T_INC - 1);
            4'd4, 4'd7: return TW'(T_WASH - 1);
            4'd10:      return TW'(T_READ - 1);
            default:    return TW'(T_FLOW - 1);
        endcase
    endfunction

    function automatic route_t route(input logic [3:0] s);
        case (s)
            4'd1:       return '{2'd1, 2'd3, 2'd2, 1'b1, 1'b0};
            4'd2:       return '{2'd0, 2'd3, 2'd1, 1'b1, 1'b0};
            4'd3, 4'd6: return '{2'd3, 2'd3, 2'd0, 1'b0, 1'b1};
            4'd4, 4'd7: return '{2'd1, 2'd3, 2'd1, 1'b1, 1'b0};
            4'd5:       return '{2'd2, 2'd0, 2'd1, 1'b1, 1'b0};
            4'd8:       return '{2'd2, 2'd1, 2'd1, 1'b1, 1'b0};
            4'd9:       return '{2'd2, 2'd2, 2'd1, 1'b1, 1'b0};
            default:    return '{2'd3, 2'd3, 2'd0, 1'b0, 1'b0};
        endcase
    endfunction

    state_t        state_q, state_d;
    logic [3:0]    step_q, step_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          err_q, err_d;
    logic [1:0]    sw41_q, sw41_d, sw42_q, sw42_d, sw31_q, sw31_d;
    logic          pump_q, pump_d, mixer_q, mixer_d, strobe_q, strobe_d;
    logic          busy_q, busy_d, done_q, done_d;
    logic          frozen;
    route_t        rt;

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        pre_d   = pre_q;
        err_d   = err_q;
        frozen  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SETTLE;
                    step_d  = 4'd1;
                    cnt_d   = SETTLE_RELOAD;
                    err_d   = 1'b0;
                end
            end
            S_SETTLE, S_ACTIVE: begin
                if (abort) begin
                    state_d = S_ABORT;
                    step_d  = STEP_ABORT;
                    err_d   = 1'b1;
                end else if (hold) begin
                    frozen = 1'b1;
                end else if (state_q == S_SETTLE) begin
                    if (cnt_q == '0) begin
                        state_d = S_ACTIVE;
                        cnt_d   = active_len(step_q);
                        pre_d   = PRE_RELOAD;
                    end else begin
                        cnt_d = cnt_q - TW'(1);
                    end
                end else if (pre_q != '0) begin
                    pre_d = pre_q - PW'(1);
                end else begin
                    pre_d = PRE_RELOAD;
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - TW'(1);
                    end else if (step_q == LAST_STEP) begin
                        state_d = S_DONE;
                        step_d  = 4'd0;
                    end else begin
                        state_d = S_SETTLE;
                        step_d  = step_q + 4'd1;
                        cnt_d   = SETTLE_RELOAD;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            S_ABORT: begin
                if (!abort) begin
                    state_d = S_IDLE;
                    step_d  = 4'd0;
                end
            end
            default: begin
                state_d = S_IDLE;
                step_d  = 4'd0;
            end
        endcase
    end

    // Outputs are decoded from the next state so every port comes straight from a flop.
    always_comb begin
        rt       = route(step_d);
        sw42_d   = 2'd3;
        sw41_d   = 2'd3;
        sw31_d   = 2'd0;
        pump_d   = 1'b0;
        mixer_d  = 1'b0;
        strobe_d = 1'b0;
        if (state_d == S_ACTIVE) begin
            sw42_d = rt.sw42;
            sw41_d = rt.sw41;
            sw31_d = rt.sw31;
            if (!frozen) begin
                pump_d   = rt.pump;
                mixer_d  = rt.mixer;
                strobe_d = (step_d == LAST_STEP) && (cnt_d == '0) && (pre_d == '0);
            end
        end
        busy_d = (state_d == S_SETTLE) || (state_d == S_ACTIVE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            step_q   <= 4'd0;
            cnt_q    <= '0;
            pre_q    <= '0;
            err_q    <= 1'b0;
            sw41_q   <= 2'd3;
            sw42_q   <= 2'd3;
            sw31_q   <= 2'd0;
            pump_q   <= 1'b0;
            mixer_q  <= 1'b0;
            strobe_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            cnt_q    <= cnt_d;
            pre_q    <= pre_d;
            err_q    <= err_d;
            sw41_q   <= sw41_d;
            sw42_q   <= sw42_d;
            sw31_q   <= sw31_d;
            pump_q   <= pump_d;
            mixer_q  <= mixer_d;
            strobe_q <= strobe_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign sw41_sel    = sw41_q;
    assign sw42_sel    = sw42_q;
    assign sw31_sel    = sw31_q;
    assign pump_en     = pump_q;
    assign mixer_en    = mixer_q;
    assign read_strobe = strobe_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign step        = step_q;

endmodule

// File: tb/tb_hiv1_assay_sequencer.sv
// Bench for hiv1_assay_sequencer: two instances (TICK_DIV=1 and 3) share random and
// directed stimulus; each is checked every cycle against a flattened-timeline model.
module tb_hiv1_assay_sequencer;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, hold = 1'b0, abort = 1'b0;
    logic [1:0] sw41 [2], sw42 [2], sw31 [2];
    logic       pump [2], mixer [2], strobe [2], busy [2], done [2], err [2];
    logic [3:0] step [2];

    always #5 clk = ~clk;

    hiv1_assay_sequencer #(.TICK_DIV(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .hold(hold), .abort(abort),
        .sw41_sel(sw41[0]), .sw42_sel(sw42[0]), .sw31_sel(sw31[0]),
        .pump_en(pump[0]), .mixer_en(mixer[0]), .read_strobe(strobe[0]),
        .busy(busy[0]), .done(done[0]), .err(err[0]), .step(step[0]));

    hiv1_assay_sequencer #(.TICK_DIV(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start), .hold(hold), .abort(abort),
        .sw41_sel(sw41[1]), .sw42_sel(sw42[1]), .sw31_sel(sw31[1]),
        .pump_en(pump[1]), .mixer_en(mixer[1]), .read_strobe(strobe[1]),
        .busy(busy[1]), .done(done[1]), .err(err[1]), .step(step[1]));

    typedef struct packed {
        logic [1:0] s42, s41, s31;
        logic       pump, mixer, strobe, busy, done, err;
        logic [3:0] step;
    } obs_t;

    int total = 0, bad = 0;

    // Protocol table, indexed by step 1..10.
    int dur_t [11] = '{0, 4, 3, 5, 4, 3, 5, 4, 3, 3, 2};
    int s42_t [11] = '{3, 1, 0, 3, 1, 2, 3, 1, 2, 2, 3};
    int s41_t [11] = '{3, 3, 3, 3, 3, 0, 3, 3, 1, 2, 3};
    int s31_t [11] = '{0, 2, 1, 0, 1, 1, 0, 1, 1, 1, 0};
    int pmp_t [11] = '{0, 1, 1, 0, 1, 1, 0, 1, 1, 1, 0};
    int mix_t [11] = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0};

    obs_t tl [2][256];
    int   tlen [2];

    localparam int M_IDLE = 0, M_BUSY = 1, M_DONE = 2, M_ABT = 3;
    int mode [2], pos [2];
    bit held [2], merr [2];
    logic [5:0] psel [2];
    int busy_cnt [2], strobe_cnt, done_cnt;

    task automatic chk(input string name, input logic ok, input longint got, input longint want);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
        end
    endtask

    function automatic void build(input int m, input int td);
        int n = 0;
        obs_t e;
        for (int s = 1; s <= 10; s++) begin
            for (int i = 0; i < 2; i++) begin
                e = '0; e.s42 = 2'd3; e.s41 = 2'd3; e.busy = 1'b1; e.step = 4'(s);
                tl[m][n++] = e;
            end
            for (int i = 0; i < dur_t[s] * td; i++) begin
                e = '0;
                e.s42 = 2'(s42_t[s]); e.s41 = 2'(s41_t[s]); e.s31 = 2'(s31_t[s]);
                e.pump = 1'(pmp_t[s]); e.mixer = 1'(mix_t[s]);
                e.strobe = (s == 10) && (i == dur_t[s] * td - 1);
                e.busy = 1'b1; e.step = 4'(s);
                tl[m][n++] = e;
            end
        end
        tlen[m] = n;
    endfunction

    function automatic obs_t expect_o(input int m);
        obs_t e = '0;
        e.s42 = 2'd3; e.s41 = 2'd3;
        case (mode[m])
            M_BUSY: begin
                e = tl[m][pos[m]];
                if (held[m]) begin e.pump = 1'b0; e.mixer = 1'b0; e.strobe = 1'b0; end
            end
            M_DONE: e.done = 1'b1;
            M_ABT:  e.step = 4'd15;
            default: ;
        endcase
        e.err = merr[m];
        return e;
    endfunction

    function automatic obs_t act_o(input int m);
        obs_t a;
        a.s42 = sw42[m]; a.s41 = sw41[m]; a.s31 = sw31[m];
        a.pump = pump[m]; a.mixer = mixer[m]; a.strobe = strobe[m];
        a.busy = busy[m]; a.done = done[m]; a.err = err[m]; a.step = step[m];
        return a;
    endfunction

    // Model: a position along the flattened protocol timeline per instance.
    always @(posedge clk or negedge rst_n) begin
        for (int m = 0; m < 2; m++) begin
            if (!rst_n) begin
                mode[m] <= M_IDLE; pos[m] <= 0; held[m] <= 1'b0; merr[m] <= 1'b0;
            end else begin
                case (mode[m])
                    M_IDLE: if (start) begin
                        mode[m] <= M_BUSY; pos[m] <= 0; held[m] <= 1'b0; merr[m] <= 1'b0;
                    end
                    M_BUSY: begin
                        if (abort) begin
                            mode[m] <= M_ABT; merr[m] <= 1'b1;
                        end else if (hold) begin
                            held[m] <= 1'b1;
                        end else begin
                            held[m] <= 1'b0;
                            if (pos[m] + 1 >= tlen[m]) mode[m] <= M_DONE;
                            else pos[m] <= pos[m] + 1;
                        end
                    end
                    M_DONE: mode[m] <= M_IDLE;
                    default: if (!abort) mode[m] <= M_IDLE;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        for (int m = 0; m < 2; m++) begin
            obs_t a, e;
            logic ok;
            a = act_o(m);
            e = expect_o(m);
            chk($sformatf("cycle_m%0d", m), a == e, a, e);
            ok = !(psel[m][5:4] != 2'd3 && a.s42 != 2'd3 && psel[m][5:4] != a.s42) &&
                 !(psel[m][3:2] != 2'd3 && a.s41 != 2'd3 && psel[m][3:2] != a.s41) &&
                 !(psel[m][1:0] != 2'd0 && a.s31 != 2'd0 && psel[m][1:0] != a.s31);
            chk($sformatf("bbm_m%0d", m), ok, {a.s42, a.s41, a.s31}, psel[m]);
            if (a.pump) chk($sformatf("pump_sw31_m%0d", m), a.s31 != 2'd0, a.s31, 1);
            psel[m] <= {a.s42, a.s41, a.s31};
            if (a.busy) busy_cnt[m] <= busy_cnt[m] + 1;
        end
        if (strobe[0]) strobe_cnt <= strobe_cnt + 1;
        if (done[0]) done_cnt <= done_cnt + 1;
    end

    function automatic logic all_idle();
        return step[0] == 4'd0 && !busy[0] && !done[0] && step[1] == 4'd0 && !busy[1] && !done[1];
    endfunction

    task automatic wait_idle();
        int n = 0;
        while (!all_idle() && n < 600) begin @(negedge clk); n++; end
        chk("idle_timeout", n < 600, n, 600);
    endtask

    task automatic wait_step(input int s, input bit need_active);
        int n = 0;
        while (!(step[0] == 4'(s) && (!need_active || sw31[0] != 2'd0)) && n < 400) begin
            @(negedge clk); n++;
        end
        chk($sformatf("wait_step%0d", s), n < 400, n, 400);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_accept", busy[0] && step[0] == 4'd1 && !err[0], {busy[0], err[0], step[0]}, 6'h21);
    endtask

    task automatic run_measure(input int want_b0, input int want_b1, input string tag);
        int b0, b1, s0, d0;
        b0 = busy_cnt[0]; b1 = busy_cnt[1]; s0 = strobe_cnt; d0 = done_cnt;
        pulse_start();
        wait_idle();
        chk({tag, "_busy1"}, busy_cnt[0] - b0 == want_b0, busy_cnt[0] - b0, want_b0);
        chk({tag, "_busy3"}, busy_cnt[1] - b1 == want_b1, busy_cnt[1] - b1, want_b1);
        chk({tag, "_strobe"}, strobe_cnt - s0 == 1, strobe_cnt - s0, 1);
        chk({tag, "_done"}, done_cnt - d0 == 1, done_cnt - d0, 1);
    endtask

    initial begin
        int b0, b1, d0;
        for (int m = 0; m < 2; m++) begin busy_cnt[m] = 0; psel[m] = 6'b111100; end
        strobe_cnt = 0; done_cnt = 0;
        build(0, 1);
        build(1, 3);
        chk("model_len1", tlen[0] == 56, tlen[0], 56);
        chk("model_len3", tlen[1] == 128, tlen[1], 128);
        chk("model_prime", tl[0][2] == 16'h7A41, tl[0][2], 16'h7A41);
        chk("model_strobe", tl[0][55].strobe && !tl[0][54].strobe, tl[0][55].strobe, 1);

        repeat (2) @(negedge clk);
        chk("rst_step", step[0] == 4'd0, step[0], 0);
        chk("rst_sel", {sw42[0], sw41[0], sw31[0]} == 6'b111100, {sw42[0], sw41[0], sw31[0]}, 6'b111100);
        chk("rst_flags", {pump[0], mixer[0], strobe[0], busy[0], done[0], err[0]} == 6'b0,
            {pump[0], mixer[0], strobe[0], busy[0], done[0], err[0]}, 0);
        rst_n = 1'b1;
        hold = 1'b1;
        repeat (3) @(negedge clk);
        hold = 1'b0;
        chk("hold_idle", step[0] == 4'd0 && !busy[0], step[0], 0);

        run_measure(56, 128, "plain");

        // Hold for 7 cycles in WASH1 ACTIVE.
        b0 = busy_cnt[0]; b1 = busy_cnt[1]; d0 = done_cnt;
        pulse_start();
        wait_step(4, 1'b1);
        hold = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk("hold_pump", pump[0] == 1'b0, pump[0], 0);
        end
        hold = 1'b0;
        wait_idle();
        chk("hold_busy1", busy_cnt[0] - b0 == 63, busy_cnt[0] - b0, 63);
        chk("hold_busy3", busy_cnt[1] - b1 == 135, busy_cnt[1] - b1, 135);
        chk("hold_done", done_cnt - d0 == 1, done_cnt - d0, 1);

        // Abort during CONJ.
        pulse_start();
        wait_step(5, 1'b0);
        abort = 1'b1;
        @(negedge clk);
        chk("abort_step", step[0] == 4'd15 && err[0] && !busy[0], {err[0], busy[0], step[0]}, 6'h2F);
        chk("abort_sel", {sw42[0], sw41[0], sw31[0], pump[0]} == 7'b1111000,
            {sw42[0], sw41[0], sw31[0], pump[0]}, 7'b1111000);
        @(negedge clk);
        chk("abort_stay", step[0] == 4'd15, step[0], 15);
        abort = 1'b0;
        @(negedge clk);
        chk("abort_idle", step[0] == 4'd0 && err[0], {err[0], step[0]}, 5'h10);
        wait_idle();
        run_measure(56, 128, "post_abort");

        // Random start/hold/abort traffic.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            start = ($urandom % 8) == 0;
            hold  = ($urandom % 5) == 0;
            abort = ($urandom % 120) == 0;
        end
        start = 1'b0; hold = 1'b0; abort = 1'b0;
        @(negedge clk);
        wait_idle();

        // Asynchronous reset mid SUBST.
        pulse_start();
        wait_step(8, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_step", step[0] == 4'd0 && !busy[0], {busy[0], step[0]}, 0);
        chk("arst_sel", {sw42[0], sw41[0], sw31[0], pump[0], mixer[0]} == 8'b11110000,
            {sw42[0], sw41[0], sw31[0], pump[0], mixer[0]}, 8'b11110000);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_measure(56, 128, "post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout got=%0t want=finish", $time);
        $fatal(1, "timeout");
    end

endmodule
